clarvi_execute: RTL and testbench
=================================

// Module: clarvi_execute
// PURPOSE
//  Byte-serial execute stage; sits between decode and memory-access.
//  Consumes one 8-bit slice per cycle from decode (de_ex_instr, rs1_value, rs2_value).
//  Produces the result slice for MA and the forwarding value for decode.
//  Resolves branches/jumps after the final slice and issues a 64-bit redirect.
// PARAMETERS
//  XLEN_BYTES      8  slices per instruction (fixed by the 64-bit datapath)
//  LINK_INC        4  link-address increment for JAL/JALR
// PORTS
//  clock            in   1    stage clock
//  reset            in   1    asynchronous, active-high
//  stall_stage      in   1    hold all state and outputs this cycle
//  stage_invalid    in   1    incoming slice is a bubble
//  de_ex_instr      in   instr_t  decoded slice (op, instr_part, immediate byte, pc, ...)
//  rs1_value        in   8    forwarded rs1 byte for de_ex_instr.instr_part
//  rs2_value        in   8    forwarded rs2 byte
//  shift_result     in   8    byte from clarvi_shift_unit; muxed in for SL/SRL/SRA
//  ex_forward_value out  8    combinational result byte (to decode forwarding)
//  ex_ma_instr      out  instr_t  registered copy of de_ex_instr
//  ex_result        out  8    registered result byte
//  ex_invalid       out  1    registered: ex_ma slot is a bubble
//  branch_valid     out  1    one-cycle redirect strobe
//  branch_target    out  64   redirect PC, valid with branch_valid
//  instr_misaligned out  1    see CONFIGURATION
// BEHAVIOUR
//  Reset (async): ex_result=0, ex_ma_instr='0, ex_invalid=1, branch_valid=0, branch_target=0,
//   instr_misaligned=0, all carry/compare state cleared.
//  Accept: a slice is accepted when !stall_stage && !stage_invalid.
//   Latency 1: ex_result/ex_ma_instr update at the next edge.
//   stage_invalid && !stall_stage -> ex_invalid=1 and internal state is untouched.
//  stall_stage: every register holds, including branch_valid.
//   branch_valid therefore stays high until the first unstalled cycle.
//  Part order: LSB-first 0..7, except SLT/SLTU which arrive MSB-first 7..0.
//   The first slice is part 0 (7 for SLT/SLTU).
//   On the first slice, internal state is taken from initial constants, never from registers,
//   so there is no leakage between instructions.
//  ADD/LOAD/STORE address: {c,r}=a+b+cin; cin=0 on first slice, else carry_q.
//   b = imm byte when immediate_used, else rs2.
//  SUB: a+~b+cin; cin=1 on first slice.
//  AND/OR/XOR: bytewise, no state.
//  LUI: result = imm byte.
//  AUIPC: pc byte + imm byte, carry chain as ADD.
//  SLT/SLTU: MSB-first.
//   decided_q is set at the first byte where rs1!=rs2.
//   lt_q = signed compare on part 7 (SLT), unsigned on all other bytes.
//   Result byte is 0 for parts 7..1; part 0 = {7'b0, lt}.
//  32-bit ops (is32_bit_op): parts 0..3 computed normally.
//   sign_q captures bit 7 of the part-3 result; parts 4..7 output {8{sign_q}}.
//  Branches (LSB-first):
//   eq_q &= (rs1==rs2).
//   borrow chain on rs1-rs2 gives LTU; at part 7, LT = sign(rs1)^sign(rs2) ? sign(rs1) : LTU.
//   Target = pc+imm, bytewise carry chain, accumulated into target_q[8p+:8].
//   Result byte not written (enable_wb=0 already).
//  JAL: target = pc+imm.
//  JALR: target = rs1+imm, then bit 0 cleared.
//  JAL/JALR result = pc+LINK_INC, using a separate link carry chain.
//  Resolution: on acceptance of part 7 of a taken branch/JAL/JALR,
//   branch_valid=1 and branch_target=target for exactly one unstalled cycle.
//   Not-taken -> no strobe.
//  Carry-out of part 7 is discarded (64-bit wrap-around).
//  Bubble between parts of one instruction: the part counter is carried in instr_part,
//   so state persists across bubbles.
//  Reset mid-instruction: all state cleared; the partial instruction is lost.
// CONFIGURATION
//  CLARVI_EX_MISALIGN_CHECK_EN defined:
//   at resolution, if target[1]==1, assert instr_misaligned instead of branch_valid
//   (one-cycle strobe, same timing).
//  Undefined: instr_misaligned tied 0; redirect always issued.
// STRUCTURE
//  riscv.svh gains:
//   - typedef ex_cmp_state_t {decided, lt, eq}
//   - localparam LINK_INC
//  Sub-module clarvi_ex_byte_alu:
//   combinational 8-bit slice (op, a, b, cin) -> (result, cout, eq, lt_byte).
//   Instantiated once for ALU/target, once for link.
// TESTING
//  ADD x=0x00000000_000000FF + 0x01 over 8 parts -> bytes 00,01,00..; carry crosses part0->1.
//  SUB 0 - 1 -> all eight result bytes 0xFF; next ADD 1+1 -> part0=0x02 (no stale carry).
//  SLTU 0x80..00 vs 0x7F..FF, parts 7..0 -> parts 7..1 = 0, part0 = 0x00.
//   SLT same operands -> part0 = 0x01.
//  BLT rs1=-1, rs2=1, pc=0x1000, imm=-8 -> branch_valid one cycle after part 7;
//   target 0x0FF8. BEQ unequal -> no strobe.
//  JALR rs1=0x2003, imm=0, pc=0x40 -> target 0x2002, link 0x44.
//   With CLARVI_EX_MISALIGN_CHECK_EN -> instr_misaligned=1, branch_valid=0.
//  ADDW 0x7FFFFFFF+1 -> bytes 00,00,00,80,FF,FF,FF,FF.
//   Assert reset during part 3 -> ex_invalid=1, all outputs 0 asynchronously.

Source files
------------

// File: rtl/clarvi_execute_pkg.sv
// Shared types for the byte-serial execute stage: op encoding, decoded slice and
// compare state carried between slices.
package clarvi_execute_pkg;

    localparam int XLEN_BYTES = 8;
    localparam int LINK_INC   = 4;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_LUI,
        OP_AUIPC, OP_SL, OP_SRL, OP_SRA, OP_LOAD, OP_STORE,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [2:0] instr_part;
        logic [7:0] immediate;
        logic [7:0] pc;
        logic       immediate_used;
        logic       is32_bit_op;
        logic       enable_wb;
    } instr_t;

    typedef struct packed {
        logic decided;
        logic lt;
        logic eq;
    } ex_cmp_state_t;

endpackage

// File: rtl/clarvi_ex_byte_alu.sv
// Combinational 8-bit ALU slice; carry in/out chain the bytes of one instruction.
module clarvi_ex_byte_alu
    import clarvi_execute_pkg::*;
(
    input  op_t        op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] result,
    output logic       cout,
    output logic       eq,
    output logic       lt_byte
);

    logic [8:0] sum;
    logic [8:0] diff;

    assign sum     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign diff    = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
    assign eq      = (a == b);
    assign lt_byte = (a < b);

    always_comb begin
        result = sum[7:0];
        cout   = sum[8];
        case (op)
            OP_SUB: begin result = diff[7:0]; cout = diff[8]; end
            OP_AND: begin result = a & b;     cout = 1'b0;    end
            OP_OR:  begin result = a | b;     cout = 1'b0;    end
            OP_XOR: begin result = a ^ b;     cout = 1'b0;    end
            OP_LUI: begin result = b;         cout = 1'b0;    end
            default: ;
        endcase
    end

endmodule

// File: rtl/clarvi_execute.sv
// Byte-serial execute stage: one 8-bit slice per cycle, branch/jump redirect after part 7.
// Optional CLARVI_EX_MISALIGN_CHECK_EN turns redirects to targets with bit 1 set into instr_misaligned.
module clarvi_execute
    import clarvi_execute_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_stage,
    input  logic        stage_invalid,
    input  instr_t      de_ex_instr,
    input  logic [7:0]  rs1_value,
    input  logic [7:0]  rs2_value,
    input  logic [7:0]  shift_result,
    output logic [7:0]  ex_forward_value,
    output instr_t      ex_ma_instr,
    output logic [7:0]  ex_result,
    output logic        ex_invalid,
    output logic        branch_valid,
    output logic [63:0] branch_target,
    output logic        instr_misaligned
);

    localparam logic [2:0] LAST_PART = 3'(XLEN_BYTES - 1);

    op_t           op, aux_op;
    logic [2:0]    part;
    logic          msb_first, branch, jump, first, accept, use_imm;
    logic [7:0]    alu_a, alu_b, alu_result, aux_a, aux_b, aux_result;
    logic          alu_cin, alu_cout, alu_eq, alu_lt, aux_cin, aux_cout, aux_eq, aux_lt_unused;
    logic          carry_q, aux_carry_q, sign_q;
    ex_cmp_state_t cmp_q, cmp_cur, cmp_next;
    logic [55:0]   target_q;
    logic [63:0]   full_target;
    logic [7:0]    result_pre, result, tgt_byte;
    logic          slt_byte_lt, ltu, lt, taken, resolve, misalign;

    assign op        = de_ex_instr.op;
    assign part      = de_ex_instr.instr_part;
    assign msb_first = op inside {OP_SLT, OP_SLTU};
    assign branch    = op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    assign jump      = op inside {OP_JAL, OP_JALR};
    assign first     = (part == (msb_first ? LAST_PART : 3'd0));
    assign accept    = !stall_stage && !stage_invalid;
    assign use_imm   = de_ex_instr.immediate_used || branch || jump || op inside {OP_LUI, OP_AUIPC};

    // Main slice: ALU result, or pc+imm target for branches and jumps.
    assign alu_a   = (branch || op inside {OP_JAL, OP_AUIPC}) ? de_ex_instr.pc : rs1_value;
    assign alu_b   = use_imm ? de_ex_instr.immediate : rs2_value;
    assign alu_cin = first ? (op == OP_SUB) : carry_q;

    clarvi_ex_byte_alu u_alu (
        .op(op), .a(alu_a), .b(alu_b), .cin(alu_cin),
        .result(alu_result), .cout(alu_cout), .eq(alu_eq), .lt_byte(alu_lt)
    );

    // Second slice: link address for jumps, rs1-rs2 borrow chain for branches.
    assign aux_op  = branch ? OP_SUB : OP_ADD;
    assign aux_a   = branch ? rs1_value : de_ex_instr.pc;
    assign aux_b   = branch ? rs2_value : ((part == 3'd0) ? 8'(LINK_INC) : 8'h00);
    assign aux_cin = first ? branch : aux_carry_q;

    clarvi_ex_byte_alu u_link (
        .op(aux_op), .a(aux_a), .b(aux_b), .cin(aux_cin),
        .result(aux_result), .cout(aux_cout), .eq(aux_eq), .lt_byte(aux_lt_unused)
    );

    assign cmp_cur     = first ? ex_cmp_state_t'{decided: 1'b0, lt: 1'b0, eq: 1'b1} : cmp_q;
    assign slt_byte_lt = (op == OP_SLT && part == LAST_PART && (alu_a[7] ^ alu_b[7])) ? alu_a[7] : alu_lt;

    always_comb begin
        cmp_next = cmp_cur;
        if (msb_first && !cmp_cur.decided && !alu_eq) begin
            cmp_next.decided = 1'b1;
            cmp_next.lt      = slt_byte_lt;
        end
        if (branch)
            cmp_next.eq = cmp_cur.eq & aux_eq;
    end

    // Only meaningful on part 7: no carry out of rs1-rs2 means rs1 < rs2 unsigned.
    assign ltu = !aux_cout;
    assign lt  = (rs1_value[7] ^ rs2_value[7]) ? rs1_value[7] : ltu;

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:          taken = cmp_next.eq;
            OP_BNE:          taken = !cmp_next.eq;
            OP_BLT:          taken = lt;
            OP_BGE:          taken = !lt;
            OP_BLTU:         taken = ltu;
            OP_BGEU:         taken = !ltu;
            OP_JAL, OP_JALR: taken = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        result_pre = alu_result;
        case (op)
            OP_SLT, OP_SLTU:     result_pre = (part == 3'd0) ? {7'd0, cmp_next.lt} : 8'h00;
            OP_SL, OP_SRL, OP_SRA: result_pre = shift_result;
            OP_JAL, OP_JALR:     result_pre = aux_result;
            default: ;
        endcase
    end

    assign result           = (de_ex_instr.is32_bit_op && part[2]) ? {8{sign_q}} : result_pre;
    assign ex_forward_value = result;

    assign tgt_byte    = (op == OP_JALR && part == 3'd0) ? {alu_result[7:1], 1'b0} : alu_result;
    assign full_target = {tgt_byte, target_q};
    assign resolve     = accept && (branch || jump) && part == LAST_PART && taken;

`ifdef CLARVI_EX_MISALIGN_CHECK_EN
    assign misalign = full_target[1];
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_result        <= 8'h00;
            ex_ma_instr      <= '0;
            ex_invalid       <= 1'b1;
            branch_valid     <= 1'b0;
            branch_target    <= 64'd0;
            instr_misaligned <= 1'b0;
            carry_q          <= 1'b0;
            aux_carry_q      <= 1'b0;
            sign_q           <= 1'b0;
            cmp_q            <= '0;
            target_q         <= 56'd0;
        end else if (!stall_stage) begin
            branch_valid     <= resolve && !misalign;
            instr_misaligned <= resolve && misalign;
            if (resolve)
                branch_target <= full_target;
            if (stage_invalid) begin
                ex_invalid <= 1'b1;
            end else begin
                ex_invalid  <= 1'b0;
                ex_ma_instr <= de_ex_instr;
                ex_result   <= result;
                carry_q     <= alu_cout;
                aux_carry_q <= aux_cout;
                cmp_q       <= cmp_next;
                if (part == 3'd3)
                    sign_q <= result_pre[7];
                for (int i = 0; i < XLEN_BYTES - 1; i++)
                    if (part == 3'(i))
                        target_q[8*i +: 8] <= tgt_byte;
            end
        end
    end

endmodule

// File: tb/tb_clarvi_execute.sv
// Self-checking bench for clarvi_execute: directed vector table, corner sequences
// (stall, bubbles, async reset) and randomized ops against a 64-bit arithmetic model.
module tb_clarvi_execute;
    import clarvi_execute_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_stage = 1'b0;
    logic        stage_invalid = 1'b1;
    instr_t      de_ex_instr = '0;
    logic [7:0]  rs1_value = 8'h00, rs2_value = 8'h00, shift_result = 8'h00;
    logic [7:0]  ex_forward_value, ex_result;
    instr_t      ex_ma_instr;
    logic        ex_invalid, branch_valid, instr_misaligned;
    logic [63:0] branch_target;

    int checks = 0;
    int errors = 0;

    clarvi_execute dut (
        .clock(clock), .reset(reset), .stall_stage(stall_stage), .stage_invalid(stage_invalid),
        .de_ex_instr(de_ex_instr), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .shift_result(shift_result), .ex_forward_value(ex_forward_value),
        .ex_ma_instr(ex_ma_instr), .ex_result(ex_result), .ex_invalid(ex_invalid),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_misaligned(instr_misaligned)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    typedef struct {
        op_t         op;
        logic [63:0] a, b, pc, imm, sh;
        logic        imm_used, is32;
        logic [63:0] exp_res;
        logic        exp_taken;
        logic [63:0] exp_tgt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic is_br(op_t op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR};
    endfunction

    function automatic logic exp_mis(logic taken, logic [63:0] tgt);
`ifdef CLARVI_EX_MISALIGN_CHECK_EN
        return taken && tgt[1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic vec_t mk(op_t op, logic [63:0] a, logic [63:0] b, logic [63:0] pc,
                                logic [63:0] imm, logic imm_used, logic is32, logic [63:0] sh,
                                logic [63:0] exp_res, logic exp_taken, logic [63:0] exp_tgt);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.pc = pc; v.imm = imm; v.sh = sh;
        v.imm_used = imm_used; v.is32 = is32;
        v.exp_res = exp_res; v.exp_taken = exp_taken; v.exp_tgt = exp_tgt;
        return v;
    endfunction

    // Reference model: whole 64-bit operands, architectural meaning of each op.
    function automatic vec_t model(vec_t v);
        logic [63:0] bb, r;
        vec_t m;
        m  = v;
        bb = v.imm_used ? v.imm : v.b;
        case (v.op)
            OP_ADD, OP_LOAD, OP_STORE: r = v.a + bb;
            OP_SUB:                    r = v.a - bb;
            OP_AND:                    r = v.a & bb;
            OP_OR:                     r = v.a | bb;
            OP_XOR:                    r = v.a ^ bb;
            OP_SLT:                    r = {63'd0, $signed(v.a) < $signed(bb)};
            OP_SLTU:                   r = {63'd0, v.a < bb};
            OP_LUI:                    r = v.imm;
            OP_AUIPC:                  r = v.pc + v.imm;
            OP_SL, OP_SRL, OP_SRA:     r = v.sh;
            OP_JAL, OP_JALR:           r = v.pc + 64'd4;
            default:                   r = 64'd0;
        endcase
        if (v.is32) r = {{32{r[31]}}, r[31:0]};
        m.exp_res = r;
        case (v.op)
            OP_BEQ:          m.exp_taken = (v.a == v.b);
            OP_BNE:          m.exp_taken = (v.a != v.b);
            OP_BLT:          m.exp_taken = ($signed(v.a) < $signed(v.b));
            OP_BGE:          m.exp_taken = ($signed(v.a) >= $signed(v.b));
            OP_BLTU:         m.exp_taken = (v.a < v.b);
            OP_BGEU:         m.exp_taken = (v.a >= v.b);
            OP_JAL, OP_JALR: m.exp_taken = 1'b1;
            default:         m.exp_taken = 1'b0;
        endcase
        m.exp_tgt = (v.op == OP_JALR) ? ((v.a + v.imm) & ~64'd1) : (v.pc + v.imm);
        return m;
    endfunction

    task automatic drive_slice(input vec_t v, input int p, input logic bubble);
        @(negedge clock);
        stall_stage                = 1'b0;
        stage_invalid              = bubble;
        de_ex_instr.op             = v.op;
        de_ex_instr.instr_part     = p[2:0];
        de_ex_instr.immediate      = v.imm[8*p +: 8];
        de_ex_instr.pc             = v.pc[8*p +: 8];
        de_ex_instr.immediate_used = v.imm_used;
        de_ex_instr.is32_bit_op    = v.is32;
        de_ex_instr.enable_wb      = !is_br(v.op) || v.op inside {OP_JAL, OP_JALR};
        rs1_value                  = v.a[8*p +: 8];
        rs2_value                  = v.b[8*p +: 8];
        shift_result               = v.sh[8*p +: 8];
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input vec_t v, output logic [63:0] res, output logic bv,
                          output logic mis, output logic [63:0] tgt);
        res = 64'd0;
        for (int k = 0; k < 8; k++) begin
            int p;
            p = (v.op inside {OP_SLT, OP_SLTU}) ? 7 - k : k;
            drive_slice(v, p, 1'b0);
            res[8*p +: 8] = ex_result;
        end
        bv = branch_valid; mis = instr_misaligned; tgt = branch_target;
    endtask

    task automatic apply_check(input string tag, input vec_t v);
        logic [63:0] res, tgt;
        logic bv, mis, em;
        run_op(v, res, bv, mis, tgt);
        em = exp_mis(v.exp_taken, v.exp_tgt);
        if (!is_br(v.op) || v.op inside {OP_JAL, OP_JALR})
            check({tag, " result"}, res, v.exp_res);
        check({tag, " branch_valid"}, {63'd0, bv}, {63'd0, v.exp_taken && !em});
        check({tag, " misaligned"}, {63'd0, mis}, {63'd0, em});
        if (v.exp_taken)
            check({tag, " target"}, tgt, v.exp_tgt);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        op_t rops[$];
        logic [63:0] acc;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset ex_invalid", {63'd0, ex_invalid}, 64'd1);
        check("reset ex_result", {56'd0, ex_result}, 64'd0);
        check("reset ex_ma_instr", {37'd0, ex_ma_instr}, 64'd0);
        check("reset branch_valid", {63'd0, branch_valid}, 64'd0);
        check("reset branch_target", branch_target, 64'd0);
        check("reset misaligned", {63'd0, instr_misaligned}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        //                 op        a                       b                       pc          imm                     iu  32  sh                      exp_res                 tk  tgt
        tbl.push_back(mk(OP_ADD,   64'hFF,                 64'h01,                 0,          0,                      0, 0, 0,                      64'h100,                0, 0));
        tbl.push_back(mk(OP_SUB,   64'h0,                  64'h1,                  0,          0,                      0, 0, 0,                      64'hFFFFFFFFFFFFFFFF,   0, 0));
        tbl.push_back(mk(OP_ADD,   64'h1,                  64'h1,                  0,          0,                      0, 0, 0,                      64'h2,                  0, 0));
        tbl.push_back(mk(OP_SLTU,  64'h8000000000000000,   64'h7FFFFFFFFFFFFFFF,   0,          0,                      0, 0, 0,                      64'h0,                  0, 0));
        tbl.push_back(mk(OP_SLT,   64'h8000000000000000,   64'h7FFFFFFFFFFFFFFF,   0,          0,                      0, 0, 0,                      64'h1,                  0, 0));
        tbl.push_back(mk(OP_BLT,   64'hFFFFFFFFFFFFFFFF,   64'h1,                  64'h1000,   64'hFFFFFFFFFFFFFFF8,   1, 0, 0,                      0,                      1, 64'h0FF8));
        tbl.push_back(mk(OP_BEQ,   64'h5,                  64'h6,                  64'h1000,   64'h40,                 1, 0, 0,                      0,                      0, 0));
        tbl.push_back(mk(OP_JALR,  64'h2003,               64'h0,                  64'h40,     64'h0,                  1, 0, 0,                      64'h44,                 1, 64'h2002));
        tbl.push_back(mk(OP_ADD,   64'h7FFFFFFF,           64'h1,                  0,          0,                      0, 1, 0,                      64'hFFFFFFFF80000000,   0, 0));
        tbl.push_back(mk(OP_XOR,   64'h00FF00FF00FF00FF,   64'h0F0F0F0F0F0F0F0F,   0,          0,                      0, 0, 0,                      64'h0FF00FF00FF00FF0,   0, 0));
        tbl.push_back(mk(OP_AND,   64'h00FF00FF00FF00FF,   64'h0F0F0F0F0F0F0F0F,   0,          0,                      0, 0, 0,                      64'h000F000F000F000F,   0, 0));
        tbl.push_back(mk(OP_OR,    64'h00FF00FF00FF00FF,   64'h0F0F0F0F0F0F0F0F,   0,          0,                      0, 0, 0,                      64'h0FFF0FFF0FFF0FFF,   0, 0));
        tbl.push_back(mk(OP_LUI,   64'hAAAA,               64'hBBBB,               0,          64'h12345000,           1, 0, 0,                      64'h12345000,           0, 0));
        tbl.push_back(mk(OP_AUIPC, 0,                      0,                      64'h1000,   64'hFFFFFFFFFFFFF000,   1, 0, 0,                      64'h0,                  0, 0));
        tbl.push_back(mk(OP_JAL,   0,                      0,                      64'hFC,     64'h100,                1, 0, 0,                      64'h100,                1, 64'h1FC));
        tbl.push_back(mk(OP_BGEU,  64'h1,                  64'hFFFFFFFFFFFFFFFF,   64'h2000,   64'h10,                 1, 0, 0,                      0,                      0, 0));
        tbl.push_back(mk(OP_SRA,   64'h1,                  64'h2,                  0,          0,                      0, 0, 64'hDEADBEEF00C0FFEE,   64'hDEADBEEF00C0FFEE,   0, 0));
        tbl.push_back(mk(OP_SUB,   64'h100,                64'h1,                  0,          0,                      0, 0, 0,                      64'hFF,                 0, 0));

        foreach (tbl[i]) begin
            apply_check($sformatf("vec%0d", i), tbl[i]);
            check($sformatf("vec%0d ex_invalid", i), {63'd0, ex_invalid}, 64'd0);
            check($sformatf("vec%0d ex_ma_instr", i), {37'd0, ex_ma_instr}, {37'd0, de_ex_instr});
        end

        // Stall keeps the redirect strobe up; the first unstalled cycle drops it.
        v = tbl[5];
        apply_check("stall blt", v);
        @(negedge clock); stall_stage = 1'b1;
        @(posedge clock); #1;
        check("stall hold bv 1", {63'd0, branch_valid}, 64'd1);
        @(posedge clock); #1;
        check("stall hold bv 2", {63'd0, branch_valid}, 64'd1);
        @(negedge clock); stall_stage = 1'b0; stage_invalid = 1'b1;
        @(posedge clock); #1;
        check("strobe drop after stall", {63'd0, branch_valid}, 64'd0);
        check("bubble ex_invalid", {63'd0, ex_invalid}, 64'd1);

        // Bubbles between parts must not disturb the carry chain.
        v = mk(OP_ADD, 64'hFF, 64'h01, 0, 0, 0, 0, 0, 0, 0, 0);
        acc = 64'd0;
        for (int p = 0; p < 8; p++) begin
            vec_t junk;
            drive_slice(v, p, 1'b0);
            acc[8*p +: 8] = ex_result;
            junk = mk(OP_SUB, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 0, 0, 0, 0, 0);
            drive_slice(junk, 0, 1'b1);
            check($sformatf("bubble%0d ex_invalid", p), {63'd0, ex_invalid}, 64'd1);
        end
        check("bubbled add result", acc, 64'h100);

        // Async reset in the middle of an ADDW.
        v = mk(OP_ADD, 64'h12345678, 64'h11, 0, 0, 0, 1, 0, 0, 0, 0);
        drive_slice(v, 0, 1'b0);
        check("latency part0", {56'd0, ex_result}, 64'h89);
        drive_slice(v, 1, 1'b0);
        drive_slice(v, 2, 1'b0);
        @(negedge clock);
        de_ex_instr.instr_part = 3'd3;
        rs1_value = 8'h12; rs2_value = 8'h00; stage_invalid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midreset ex_invalid", {63'd0, ex_invalid}, 64'd1);
        check("midreset ex_result", {56'd0, ex_result}, 64'd0);
        check("midreset ex_ma_instr", {37'd0, ex_ma_instr}, 64'd0);
        check("midreset branch_target", branch_target, 64'd0);
        check("midreset branch_valid", {63'd0, branch_valid}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        apply_check("post reset add", tbl[2]);

        // Randomized ops against the model.
        rops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC,
                 OP_SRL, OP_LOAD, OP_STORE, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
                 OP_JAL, OP_JALR};
        for (int n = 0; n < 250; n++) begin
            v.op  = rops[$urandom_range(0, rops.size() - 1)];
            v.a   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       v.b = v.a;
                1:       v.b = {v.a[63:8], 8'($urandom)};
                2:       v.b = {v.a[63:32], $urandom};
                default: v.b = {$urandom, $urandom};
            endcase
            v.pc  = {$urandom, $urandom};
            v.imm = {$urandom, $urandom};
            v.sh  = {$urandom, $urandom};
            v.imm_used = (v.op inside {OP_ADD, OP_LOAD, OP_STORE}) ? 1'($urandom) : 1'b0;
            v.is32     = (v.op inside {OP_ADD, OP_SUB}) ? 1'($urandom) : 1'b0;
            if (is_br(v.op) || v.op inside {OP_LUI, OP_AUIPC}) v.imm_used = 1'b1;
            v = model(v);
            apply_check($sformatf("rand%0d %s", n, v.op.name()), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
